// File: rtl/controle_registrador.sv
// controle_registrador: round-robin arbiter sequencing parallel and serial loads into a shared shift register
module controle_registrador #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_par,
  input  logic [N-1:0] din_par,
  input  logic         req_ser,
  input  logic [N-1:0] din_ser,
  input  logic [N-1:0] reg_Dout,
  output logic         reg_SEL,
  output logic [N-1:0] reg_Din,
  output logic         reg_Din_serie,
  output logic         grant_par,
  output logic         grant_ser,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] word_out
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, PAR, SER, DONE} state_t;
  state_t state;
  logic [N-1:0] dbuf;
  logic [CW-1:0] cnt;
  logic last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      dbuf <= '0;
      last <= 1'b1;
      word_out <= '0;
    end else begin
      case (state)
        IDLE:
          if (req_par && (!req_ser || last)) begin
            state <= PAR;
            dbuf <= din_par;
            last <= 1'b0;
            cnt <= '0;
          end else if (req_ser) begin
            state <= SER;
            dbuf <= din_ser;
            last <= 1'b1;
            cnt <= '0;
          end
        PAR: state <= DONE;
        SER: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= DONE;
        end
        default: begin
          word_out <= reg_Dout;
          state <= IDLE;
        end
      endcase
    end
  end
  // the register has no enable, so every non-loading cycle feeds its output back
  always_comb begin
    grant_par = state == PAR;
    grant_ser = state == SER;
    busy = state != IDLE;
    done = state == DONE;
    reg_SEL = grant_ser;
    reg_Din = grant_par ? dbuf : reg_Dout;
    reg_Din_serie = grant_ser ? dbuf[CW'(N - 1) - cnt] : 1'b0;
  end
endmodule
